// File: rtl/nds_sync_fifo_lvl.sv
// nds_sync_fifo_lvl: single-clock FIFO with fill level, almost-full/empty
// thresholds, sticky overflow/underflow flags, synchronous flush and a
// selectable first-word-fall-through or registered read port.
// Depth may be any value >= 2; pointers wrap explicitly at FIFO_DEPTH-1.
`timescale 1ns/1ps
module nds_sync_fifo_lvl #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int COUNT_WIDTH  = 4,
  parameter int AFULL_THRES  = 6,
  parameter int AEMPTY_THRES = 2,
  parameter int RD_MODE      = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   wr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   rd,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  input  logic                   err_clr,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int                     PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]       LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0]       PTR_ONE    = PTR_W'(1);
  localparam logic [COUNT_WIDTH-1:0] DEPTH_CNT  = COUNT_WIDTH'(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] AFULL_CNT  = COUNT_WIDTH'(AFULL_THRES);
  localparam logic [COUNT_WIDTH-1:0] AEMPTY_CNT = COUNT_WIDTH'(AEMPTY_THRES);

  logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_overflow;
  logic                   r_underflow;

  logic w_empty;
  logic w_full;
  logic w_wa;
  logic w_ra;

  // Explicit wrap so non-power-of-2 depths need no extra pointer bit.
  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : (p + PTR_ONE);
  endfunction

  // Status comes from the registered count only, never from this cycle's requests.
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == DEPTH_CNT);
  assign w_wa         = wr & ~w_full & ~flush;
  assign w_ra         = rd & ~w_empty & ~flush;

  assign count        = r_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (r_count <= AEMPTY_CNT);
  assign almost_full  = (r_count >= AFULL_CNT);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Pointer and level bookkeeping; flush overrides any request in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wa) r_wr_ptr <= f_next_ptr(r_wr_ptr);
      if (w_ra) r_rd_ptr <= f_next_ptr(r_rd_ptr);
      if (w_wa && !w_ra)      r_count <= r_count + CNT_ONE;
      else if (w_ra && !w_wa) r_count <= r_count - CNT_ONE;
    end
  end

  // Sticky error flags; a new set event beats err_clr in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (wr & w_full & ~flush)  | (r_overflow  & ~err_clr);
      r_underflow <= (rd & w_empty & ~flush) | (r_underflow & ~err_clr);
    end
  end

  // Storage array is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (w_wa) r_mem[r_wr_ptr] <= wr_data;
  end

  generate
    if (RD_MODE == 0) begin : g_fwft
      assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
      assign rd_valid = ~w_empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_rd_data;
      logic                  r_rd_valid;

      // Registered read: data lands one cycle after the accepted read and is held otherwise.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_ra;
          if (w_ra) r_rd_data <= r_mem[r_rd_ptr];
        end
      end

      assign rd_data  = r_rd_data;
      assign rd_valid = r_rd_valid;
    end
  endgenerate

endmodule
